uptime_bcd_ctr: RTL and testbench

Parametrised BCD uptime/event counter. It is the next-generation uptime block: P_DIGITS packed BCD digits, gated by a single-cycle tick_en strobe. Over the earlier up-only counter it adds:
- up/down counting
- synchronous clear and load
- wrap or saturate at the terminal value
- a sticky overflow flag
- a registered carry pulse
- a snapshot register for readout

It sits between a prescaler (tick_en source) and display/readout logic.

---
 rtl/uptime_bcd_ctr.sv | 118 +++++++++++
 tb/tb_uptime_bcd_ctr.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uptime_bcd_ctr.sv
// Parametrised packed-BCD uptime/event counter: up/down, clear, load, wrap or
// saturate, sticky overflow, carry pulse, snapshot. Macro UPTIME_BLANK_EN adds the blank mask.
module uptime_bcd_ctr #(
  parameter int P_DIGITS = 3,
  parameter bit P_SAT    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [P_DIGITS*4-1:0] load_val,
  input  logic                  snap,
  output logic [P_DIGITS*4-1:0] digits,
  output logic [P_DIGITS*4-1:0] snap_digits,
  output logic                  carry_o,
  output logic                  ovf,
  output logic                  load_err,
  output logic [P_DIGITS-1:0]   blank
);

  localparam int W = P_DIGITS * 4;

  logic [W-1:0] cnt_next, digits_d;
  logic [3:0]   nib;
  logic         ripple, all9, all0, load_ok, terminal;
  logic         ovf_d, carry_d, load_err_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    cnt_next   = digits;
    digits_d   = digits;
    ovf_d      = ovf;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    nib        = 4'd0;
    ripple     = 1'b1;
    all9       = 1'b1;
    all0       = 1'b1;
    load_ok    = 1'b1;

    // A digit steps only while every lower digit is at its roll-over value.
    for (int i = 0; i < P_DIGITS; i++) begin
      nib = digits[4*i +: 4];
      if (nib != 4'd9) all9 = 1'b0;
      if (nib != 4'd0) all0 = 1'b0;
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
      if (ripple) begin
        if (up) begin
          cnt_next[4*i +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
          ripple             = (nib == 4'd9);
        end else begin
          cnt_next[4*i +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
          ripple             = (nib == 4'd0);
        end
      end
    end

    terminal = up ? all9 : all0;

    if (clr) begin
      digits_d = '0;
      ovf_d    = 1'b0;
    end else if (load) begin
      if (load_ok) digits_d = load_val;
      else         load_err_d = 1'b1;
    end else if (tick_en) begin
      if (terminal) begin
        carry_d = 1'b1;
        ovf_d   = 1'b1;
        if (!P_SAT) digits_d = cnt_next;
      end else begin
        digits_d = cnt_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      digits      <= '0;
      snap_digits <= '0;
      carry_o     <= 1'b0;
      ovf         <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      digits   <= digits_d;
      carry_o  <= carry_d;
      ovf      <= ovf_d;
      load_err <= load_err_d;
      if (snap) snap_digits <= digits;
    end
  end

`ifdef UPTIME_BLANK_EN
  logic [P_DIGITS-1:0] blank_d;
  logic                zero_above;

  // Computed from the next count so the mask stays aligned with digits.
  always_comb begin
    blank_d    = '0;
    zero_above = 1'b1;
    for (int i = P_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (digits_d[4*i +: 4] == 4'd0);
      blank_d[i] = zero_above;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) blank <= '0;
    else      blank <= blank_d;
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_uptime_bcd_ctr.sv
// Scoreboard bench for uptime_bcd_ctr: a wrapping and a saturating instance share
// stimulus; an integer model predicts each cycle's outputs.
module tb_uptime_bcd_ctr;

  localparam int ND   = 3;
  localparam int MAXV = 999;

  logic clk = 1'b0;
  logic rst, tick_en, up, clr, load, snap;
  logic [ND*4-1:0] load_val;

  logic [ND*4-1:0] dig_w, snp_w, dig_s, snp_s;
  logic            car_w, ovf_w, le_w, car_s, ovf_s, le_s;
  logic [ND-1:0]   blk_w, blk_s;

  uptime_bcd_ctr #(.P_DIGITS(ND), .P_SAT(1'b0)) dut_w (
    .clk(clk), .rst(rst), .tick_en(tick_en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .snap(snap), .digits(dig_w), .snap_digits(snp_w),
    .carry_o(car_w), .ovf(ovf_w), .load_err(le_w), .blank(blk_w));

  uptime_bcd_ctr #(.P_DIGITS(ND), .P_SAT(1'b1)) dut_s (
    .clk(clk), .rst(rst), .tick_en(tick_en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .snap(snap), .digits(dig_s), .snap_digits(snp_s),
    .carry_o(car_s), .ovf(ovf_s), .load_err(le_s), .blank(blk_s));

  always #5 clk = ~clk;

  typedef struct {
    logic [ND*4-1:0] digits;
    logic [ND*4-1:0] snap;
    logic            carry;
    logic            ovf;
    logic            lerr;
    logic [ND-1:0]   blank;
  } exp_t;

  exp_t sb[$];
  int   m_val[2];
  int   m_snap[2];
  logic m_ovf[2];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [ND*4-1:0] v);
    int r = 0;
    for (int i = ND - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [ND*4-1:0] int2bcd(input int v);
    logic [ND*4-1:0] r = '0;
    int x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [ND*4-1:0] v);
    for (int i = 0; i < ND; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Digit i and all above are zero exactly when the value is below 10**i.
  function automatic logic [ND-1:0] exp_blank(input int v);
    logic [ND-1:0] r = '0;
`ifdef UPTIME_BLANK_EN
    int p = 1;
    for (int i = 1; i < ND; i++) begin
      p = p * 10;
      r[i] = (v < p);
    end
`endif
    return r;
  endfunction

  task automatic compare_outputs();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      string pfx = (k == 0) ? "wrap" : "sat";
      if (sb.size() == 0) begin
        check({pfx, ".scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({pfx, ".digits"}, 32'(k == 0 ? dig_w : dig_s), 32'(e.digits));
        check({pfx, ".snap_digits"}, 32'(k == 0 ? snp_w : snp_s), 32'(e.snap));
        check({pfx, ".carry_o"}, 32'(k == 0 ? car_w : car_s), 32'(e.carry));
        check({pfx, ".ovf"}, 32'(k == 0 ? ovf_w : ovf_s), 32'(e.ovf));
        check({pfx, ".load_err"}, 32'(k == 0 ? le_w : le_s), 32'(e.lerr));
        check({pfx, ".blank"}, 32'(k == 0 ? blk_w : blk_s), 32'(e.blank));
      end
    end
  endtask

  // Drive one cycle of stimulus, predict the result, then compare after the edge.
  task automatic step(input logic t, input logic u, input logic c, input logic l,
                      input logic [ND*4-1:0] lv, input logic s);
    exp_t e;
    tick_en = t; up = u; clr = c; load = l; load_val = lv; snap = s;
    for (int k = 0; k < 2; k++) begin
      e.carry = 1'b0;
      e.lerr  = 1'b0;
      if (s) m_snap[k] = m_val[k];
      if (c) begin
        m_val[k] = 0;
        m_ovf[k] = 1'b0;
      end else if (l) begin
        if (bcd_ok(lv)) m_val[k] = bcd2int(lv);
        else            e.lerr = 1'b1;
      end else if (t) begin
        if ((u && m_val[k] == MAXV) || (!u && m_val[k] == 0)) begin
          e.carry  = 1'b1;
          m_ovf[k] = 1'b1;
          if (k == 0) m_val[k] = u ? 0 : MAXV;
        end else begin
          m_val[k] = u ? m_val[k] + 1 : m_val[k] - 1;
        end
      end
      e.digits = int2bcd(m_val[k]);
      e.snap   = int2bcd(m_snap[k]);
      e.ovf    = m_ovf[k];
      e.blank  = exp_blank(m_val[k]);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k]  = 0;
      m_snap[k] = 0;
      m_ovf[k]  = 1'b0;
    end
  endtask

  task automatic check_reset_values();
    check("rst.digits", 32'({dig_w, dig_s}), 32'd0);
    check("rst.snap_digits", 32'({snp_w, snp_s}), 32'd0);
    check("rst.flags", 32'({car_w, ovf_w, le_w, car_s, ovf_s, le_s}), 32'd0);
    check("rst.blank", 32'({blk_w, blk_s}), 32'd0);
  endtask

  initial begin
    rst = 1'b0; tick_en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; snap = 1'b0;
    load_val = '0;
    model_reset();
    #2;
    check_reset_values();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Count up, one tick every fourth cycle: 000 .. 010.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      idle(3);
    end
    check("count.final", 32'(dig_w), 32'h010);

    // Wrap at 999 (saturating instance holds), carry pulses once, ovf sticks; clr drops ovf.
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h999, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Count down through zero: wrap gives 999, 998; saturate holds 000 with repeated carry.
    step(1'b0, 1'b0, 1'b0, 1'b1, 12'h002, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(1);

    // Bad load beside a tick is rejected and the tick dropped; a good load follows.
    step(1'b1, 1'b1, 1'b0, 1'b1, 12'h1A3, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h123, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h90F, 1'b0);

    // clr beats load and tick; snap captures the pre-clear value.
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h045, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 12'h777, 1'b1);

    // Blank mask patterns.
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h007, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h100, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);

    // Tick held high across a digit boundary with direction changes.
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h097, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Mixed random traffic.
    for (int i = 0; i < 200; i++) begin
      logic [ND*4-1:0] lv;
      lv = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                       : int2bcd($urandom_range(0, MAXV));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 12) == 0),
           lv, 1'($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset mid-count, checked before the next clock edge.
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h456, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    tick_en = 1'b0; load = 1'b0; snap = 1'b0; clr = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    #1 rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
